class_argmax: RTL and testbench



---
 rtl/class_argmax_pkg.sv | 18 +
 rtl/class_cmp.sv | 13 +
 rtl/class_argmax.sv | 156 +++++++++++++++
 tb/tb_class_argmax.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/class_argmax_pkg.sv
// Shared constants for the zyNet final-layer argmax stage: default geometry,
// index width and the IDLE/SCAN/DONE state encoding.
package class_argmax_pkg;

  localparam int CA_DATA_WIDTH  = 16;  // dataWidth: one final-layer neuron output
  localparam int CA_NUM_CLASSES = 10;  // numClasses: final-layer neuron count
  localparam int CA_IDX_W       = 32;  // reported index width (AXI register width)

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter width for a scan over n elements; never below one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/class_cmp.sv
// Signed greater-than on two DATA_WIDTH operands; shared with the
// hardmax/softmax variants of the output stage.
module class_cmp #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_gt
);

  assign o_gt = $signed(i_a) > $signed(i_b);

endmodule

// File: rtl/class_argmax.sv
// Sequential argmax over the final fully-connected layer outputs, one class
// per cycle. Define CLASS_SCORE_EN to add the o_score (winning value) port.
module class_argmax
  import class_argmax_pkg::*;
#(
  parameter int DATA_WIDTH  = CA_DATA_WIDTH,
  parameter int NUM_CLASSES = CA_NUM_CLASSES,
  parameter int IDX_W       = CA_IDX_W
) (
  input  logic                              s_axi_aclk,
  input  logic                              s_axi_aresetn,
  input  logic                              soft_rst,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] i_data,
  input  logic                              i_valid,
  input  logic                              intr_clr,
  output logic                              o_busy,
  output logic [IDX_W-1:0]                  o_index,
  output logic                              o_valid,
  output logic                              intr,
`ifdef CLASS_SCORE_EN
  output logic [DATA_WIDTH-1:0]             o_score,
`endif
  output logic                              o_overrun
);

  localparam int CNT_W = cnt_width(NUM_CLASSES);

  logic [1:0]                        r_state;
  logic [CNT_W-1:0]                  r_cnt;
  logic [NUM_CLASSES*DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0]             r_max_val;
  logic [CNT_W-1:0]                  r_max_idx;
  logic [IDX_W-1:0]                  r_index;
  logic                              r_valid;
  logic                              r_intr;
  logic                              r_overrun;

  logic [DATA_WIDTH-1:0] w_elem;
  logic                  w_gt;
  logic                  w_last;
  logic                  w_accept;
  logic                  w_enter_done;
  logic [DATA_WIDTH-1:0] w_next_val;
  logic [CNT_W-1:0]      w_next_idx;

  assign w_elem       = r_data[int'(r_cnt)*DATA_WIDTH +: DATA_WIDTH];
  assign w_last       = (r_cnt == CNT_W'(NUM_CLASSES - 1));
  assign w_accept     = (r_state == IDLE) && i_valid;
  assign w_enter_done = (r_state == SCAN) && w_last;

  class_cmp #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmp (
    .i_a  (w_elem),
    .i_b  (r_max_val),
    .o_gt (w_gt)
  );

  // Strict greater-than only, so ties keep the earlier (lower) index.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next_val = r_max_val;
    w_next_idx = r_max_idx;
    if (w_gt) begin
      w_next_val = w_elem;
      w_next_idx = r_cnt;
    end
  end

  // NOTE: the latched vector and running max are pure datapath, written only on
  // accept/scan, so they carry no reset; control decides when they are meaningful.
  always_ff @(posedge s_axi_aclk) begin
    if (w_accept) begin
      r_data    <= i_data;
      r_max_val <= i_data[0 +: DATA_WIDTH];
      r_max_idx <= '0;
    end else if (r_state == SCAN) begin
      r_max_val <= w_next_val;
      r_max_idx <= w_next_idx;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_index   <= '0;
      r_valid   <= 1'b0;
      r_intr    <= 1'b0;
      r_overrun <= 1'b0;
    end else if (soft_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_index   <= '0;
      r_valid   <= 1'b0;
      r_intr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_state <= SCAN;
            r_cnt   <= CNT_W'(1);
          end
        end
        SCAN: begin
          if (w_last) begin
            r_state <= DONE;
            r_index <= IDX_W'(w_next_idx);
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      // Set is held through the DONE cycle so a coinciding clear loses.
      if (w_enter_done || (r_state == DONE)) begin
        r_intr <= 1'b1;
      end else if (intr_clr) begin
        r_intr <= 1'b0;
      end

      if (i_valid && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

`ifdef CLASS_SCORE_EN
  logic [DATA_WIDTH-1:0] r_score;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_score <= '0;
    end else if (soft_rst) begin
      r_score <= '0;
    end else if (w_enter_done) begin
      r_score <= w_next_val;
    end
  end

  assign o_score = r_score;
`endif

  assign o_busy    = (r_state != IDLE);
  assign o_index   = r_index;
  assign o_valid   = r_valid;
  assign intr      = r_intr;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_class_argmax.sv
// Scoreboard bench for class_argmax: expected winners are queued at stimulus
// time and compared whenever the DUT pulses o_valid.
module tb_class_argmax;

  localparam int DW = 16;
  localparam int N  = 10;
  localparam int IW = 32;

  logic              clk;
  logic              rst_n;
  logic              soft_rst;
  logic [N*DW-1:0]   i_data;
  logic              i_valid;
  logic              intr_clr;
  logic              o_busy;
  logic [IW-1:0]     o_index;
  logic              o_valid;
  logic              intr;
  logic              o_overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  class_argmax #(
    .DATA_WIDTH  (DW),
    .NUM_CLASSES (N),
    .IDX_W       (IW)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .soft_rst      (soft_rst),
    .i_data        (i_data),
    .i_valid       (i_valid),
    .intr_clr      (intr_clr),
    .o_busy        (o_busy),
    .o_index       (o_index),
    .o_valid       (o_valid),
    .intr          (intr),
    .o_overrun     (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference argmax: signed compare, strict greater keeps the lowest index on ties.
  function automatic int model(input logic [N*DW-1:0] v);
    int best = 0;
    logic signed [DW-1:0] bv;
    logic signed [DW-1:0] e;
    bv = v[0 +: DW];
    for (int i = 1; i < N; i++) begin
      e = v[i*DW +: DW];
      if (e > bv) begin
        bv   = e;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] val);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = val;
    return v;
  endfunction

  // Scoreboard consumer: every o_valid pulse must match the oldest queued winner.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        check("sb_index", o_index, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives i_valid for cycle T; returns positioned in cycle T+1.
  task automatic send(input logic [N*DW-1:0] v, input bit expect_result);
    step();
    i_data  = v;
    i_valid = 1'b1;
    if (expect_result) exp_q.push_back(model(v));
    step();
    i_valid = 1'b0;
  endtask

  // Walks cycles T+1..T+N+1 checking busy/valid/intr timing.
  task automatic run_timed(input string tag, input logic [N*DW-1:0] v);
    send(v, 1'b1);
    for (int k = 1; k <= N; k++) begin
      check({tag, "_busy"}, o_busy, 1);
      check({tag, "_valid"}, o_valid, (k == N) ? 1 : 0);
      if (k < N) step();
    end
    check({tag, "_intr"}, intr, 1);
    step();
    check({tag, "_busy_end"}, o_busy, 0);
    check({tag, "_valid_end"}, o_valid, 0);
  endtask

  task automatic clear_intr();
    step();
    intr_clr = 1'b1;
    step();
    intr_clr = 1'b0;
    check("intr_cleared", intr, 0);
  endtask

  logic [N*DW-1:0] v_a;
  logic [N*DW-1:0] v_b;
  logic [N*DW-1:0] v_r;

  initial begin
    rst_n    = 1'b0;
    soft_rst = 1'b0;
    i_data   = '0;
    i_valid  = 1'b0;
    intr_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_index", o_index, 0);
    check("rst_valid", o_valid, 0);
    check("rst_intr", intr, 0);
    check("rst_overrun", o_overrun, 0);
    rst_n = 1'b1;

    // Mixed positive values, class 1 wins.
    v_a = '0;
    v_a[0*DW +: DW] = 16'h0010; v_a[1*DW +: DW] = 16'h0200;
    v_a[2*DW +: DW] = 16'h0050; v_a[3*DW +: DW] = 16'h0030;
    v_a[4*DW +: DW] = 16'h0040; v_a[5*DW +: DW] = 16'h0007;
    v_a[6*DW +: DW] = 16'h0100; v_a[7*DW +: DW] = 16'h01FF;
    v_a[8*DW +: DW] = 16'h0020; v_a[9*DW +: DW] = 16'h0001;
    run_timed("tp1", v_a);
    check("tp1_index", o_index, 1);
    clear_intr();

    // Last element is the winner.
    v_b = '0;
    v_b[9*DW +: DW] = 16'h7FFF;
    run_timed("last", v_b);
    check("last_index", o_index, 9);

    // All equal: ties keep index 0.
    run_timed("ties", fill(16'h0100));
    check("ties_index", o_index, 0);

    // Signed: -2 beats the most-negative value everywhere else.
    v_b = fill(16'h8000);
    v_b[3*DW +: DW] = 16'hFFFE;
    run_timed("signed", v_b);
    check("signed_index", o_index, 3);
    clear_intr();

    // Overrun at T+4 with other data; intr_clr coincides with DONE.
    v_a = fill(16'h0005);
    v_a[5*DW +: DW] = 16'h0300;
    v_b = fill(16'h0001);
    v_b[2*DW +: DW] = 16'h7000;
    send(v_a, 1'b1);
    for (int k = 1; k <= N; k++) begin
      i_valid  = (k == 4);
      i_data   = (k == 4) ? v_b : v_a;
      intr_clr = (k == N);
      step();
    end
    i_valid  = 1'b0;
    intr_clr = 1'b0;
    check("ovr_intr_kept", intr, 1);
    check("ovr_flag", o_overrun, 1);
    check("ovr_index", o_index, 5);
    repeat (4) step();
    check("ovr_flag_sticky", o_overrun, 1);
    clear_intr();

    // soft_rst mid-scan aborts silently and clears sticky flags.
    send(v_b, 1'b0);
    repeat (2) step();
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    check("srst_busy", o_busy, 0);
    check("srst_overrun", o_overrun, 0);
    check("srst_index", o_index, 0);
    repeat (N + 2) step();
    check("srst_no_intr", intr, 0);

    // Async reset at T+5 mid-scan: outputs drop at once, no result.
    send(v_b, 1'b0);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("arst_busy", o_busy, 0);
    check("arst_valid", o_valid, 0);
    check("arst_index", o_index, 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (N + 2) step();
    check("arst_no_intr", intr, 0);

    // Fresh vectors after reset, including random ones.
    run_timed("post_rst", v_b);
    check("post_rst_index", o_index, 2);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) v_r[i*DW +: DW] = DW'($urandom_range(0, 65535));
      if (r == 0) v_r[7*DW +: DW] = v_r[2*DW +: DW];
      run_timed("rand", v_r);
    end

    begin
      int budget = 50;
      while (exp_q.size() != 0 && budget > 0) begin
        step();
        budget--;
      end
    end
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
